// File: rtl/cve2_obi_mem_responder.sv
// Word-addressed on-chip RAM answering req/gnt/rvalid bus requests in order, with a small
// response FIFO so pipelined requests work, plus stall/hold hooks for protocol testing.
module cve2_obi_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        stall_i,
    input  logic        resp_hold_i
);

    localparam int unsigned IdxW = $clog2(MemWords);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [32:0]     RangeBytes = 33'(MemWords) << 2;
    localparam logic [PtrW-1:0] LastPtr    = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] MaxCount   = CntW'(MaxOutstanding);

    logic [31:0]     mem        [MemWords];
    logic [31:0]     fifo_rdata [MaxOutstanding];
    logic            fifo_err   [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;

    logic [31:0]     offset;
    logic            in_range;
    logic [IdxW-1:0] idx;
    logic            push;
    logic            pop;
    logic [31:0]     push_rdata;
    logic            push_err;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // The unsigned subtraction makes addresses below BaseAddr wrap to huge offsets, so a single
    // compare covers both ends of the window.
    assign offset   = addr_i - BaseAddr;
    assign in_range = {1'b0, offset} < RangeBytes;
    assign idx      = offset[2 +: IdxW];

    assign pop   = (count != '0) & ~resp_hold_i;
    assign gnt_o = rst_ni & req_i & ~stall_i & ((count < MaxCount) | pop);
    assign push  = gnt_o;

    always_comb begin
        push_rdata = '0;
        push_err   = ~in_range;
        if (in_range && !we_i) begin
            push_rdata = mem[idx];
        end
    end

    // RAM contents survive reset; gnt_o is already low while rst_ni is asserted.
    always_ff @(posedge clk_i) begin
        if (push && we_i && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rdata[wr_ptr] <= push_rdata;
            fifo_err[wr_ptr]   <= push_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CntW'(push) - CntW'(pop);
        end
    end

    assign rvalid_o = pop;
    assign rdata_o  = pop ? fifo_rdata[rd_ptr] : '0;
    assign err_o    = pop & fifo_err[rd_ptr];

`ifndef SYNTHESIS
    a_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({gnt_o, rvalid_o}));
    a_count_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= MaxCount);
    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> (count != '0));
`endif

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// Bench for cve2_obi_mem_responder: directed protocol scenarios plus randomized traffic,
// checked every cycle against a queue-and-array model of the memory and its responses.
module tb_cve2_obi_mem_responder;

    localparam int          MemWords = 1024;
    localparam logic [31:0] BaseAddr = 32'h0000_0000;
    localparam int          MaxOut   = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        stall_i = 1'b0;
    logic        resp_hold_i = 1'b0;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    cve2_obi_mem_responder #(
        .MemWords(MemWords),
        .BaseAddr(BaseAddr),
        .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .req_i(req_i),
        .gnt_o(gnt_o),
        .we_i(we_i),
        .be_i(be_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .rvalid_o(rvalid_o),
        .rdata_o(rdata_o),
        .err_o(err_o),
        .stall_i(stall_i),
        .resp_hold_i(resp_hold_i)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_mem [MemWords];
    resp_t       q [$];
    logic        exp_gnt;
    logic        exp_pop;
    logic        last_gnt;
    logic        last_rvalid;
    logic [31:0] last_rdata;
    logic        last_err;
    int          dut_grants;
    int          dut_rvalids;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_i   = req;
        we_i    = we;
        be_i    = be;
        addr_i  = addr;
        wdata_i = wdata;
    endtask

    // Effect of one accepted request on the model: the response it will produce and any write.
    task automatic modelAccept();
        logic [31:0] off;
        int          idx;
        resp_t       r;
        off = addr_i - BaseAddr;
        if (off < 32'(4 * MemWords)) begin
            idx     = int'(off >> 2);
            r.err   = 1'b0;
            r.rdata = we_i ? 32'h0 : model_mem[idx];
            if (we_i) begin
                for (int k = 0; k < 4; k++) begin
                    if (be_i[k]) model_mem[idx][8*k +: 8] = wdata_i[8*k +: 8];
                end
            end
        end else begin
            r.rdata = 32'h0;
            r.err   = 1'b1;
        end
        q.push_back(r);
    endtask

    // One clock: outputs are compared at the falling edge, the model advances at the rising edge.
    task automatic clockCycle();
        @(negedge clk_i);
        exp_pop = rst_ni && (q.size() != 0) && !resp_hold_i;
        exp_gnt = rst_ni && req_i && !stall_i && ((q.size() < MaxOut) || exp_pop);
        checkOutput("gnt", 32'(gnt_o), 32'(exp_gnt));
        checkOutput("rvalid", 32'(rvalid_o), 32'(exp_pop));
        checkOutput("rdata", rdata_o, exp_pop ? q[0].rdata : 32'h0);
        checkOutput("err", 32'(err_o), exp_pop ? 32'(q[0].err) : 32'h0);
        last_gnt    = gnt_o;
        last_rvalid = rvalid_o;
        if (gnt_o) dut_grants++;
        if (rvalid_o) dut_rvalids++;
        if (exp_pop) begin
            last_rdata = rdata_o;
            last_err   = err_o;
        end
        @(posedge clk_i);
        if (rst_ni) begin
            if (exp_pop) void'(q.pop_front());
            if (exp_gnt) modelAccept();
        end
        #1;
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
        int n = 0;
        applyStimulus(1'b1, we, be, addr, wdata);
        do begin
            clockCycle();
            n++;
        end while (!exp_gnt && n < 50);
        checkOutput("grant_timeout", 32'(n < 50), 32'h1);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        while (q.size() != 0 && n < 50) begin
            clockCycle();
            n++;
        end
        checkOutput("drain_timeout", 32'(q.size()), 32'h0);
    endtask

    task automatic readBack(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        access(1'b0, addr, 4'h0, 32'h0);
        drain();
        checkOutput(tag, last_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        logic [31:0] a;

        // Reset: no grant even with a request pending, no response.
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        clockCycle();
        clockCycle();
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst_ni = 1'b1;
        clockCycle();

        // Full write then readback, minimum latency.
        access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        clockCycle();
        checkOutput("wr_resp_rvalid", 32'(last_rvalid), 32'h1);
        checkOutput("wr_resp_rdata", last_rdata, 32'h0);
        readBack("rd_deadbeef", 32'h10, 32'hDEADBEEF);

        // Byte-enabled write.
        access(1'b1, 32'h10, 4'b0101, 32'h11223344);
        drain();
        readBack("rd_be_merge", 32'h10, 32'hDE22BE44);

        for (int w = 0; w < 16; w++) begin
            if (w != 4) access(1'b1, 32'(4 * w), 4'hF, $urandom);
        end
        drain();

        // Pipelined reads against a held response FIFO.
        resp_hold_i = 1'b1;
        dut_grants = 0;
        begin
            int i = 0;
            applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
            for (int c = 0; c < 4; c++) begin
                clockCycle();
                if (exp_gnt) begin
                    i++;
                    addr_i = 32'(4 * i);
                end
            end
            checkOutput("hold_grants", 32'(dut_grants), 32'h2);
            resp_hold_i = 1'b0;
            clockCycle();
            checkOutput("third_gnt_with_pop", {30'h0, last_gnt, last_rvalid}, 32'h3);
            drain();
        end

        // Out-of-range accesses.
        access(1'b0, BaseAddr + 32'(4 * MemWords), 4'h0, 32'h0);
        drain();
        checkOutput("oor_rd_err", 32'(last_err), 32'h1);
        checkOutput("oor_rd_rdata", last_rdata, 32'h0);
        access(1'b1, 32'hFFFF_FFFC, 4'hF, 32'h55AA55AA);
        drain();
        checkOutput("oor_wr_err", 32'(last_err), 32'h1);
        readBack("rd_word0_unchanged", 32'h0, model_mem[0]);

        // Stall hook.
        stall_i = 1'b1;
        dut_grants = 0;
        dut_rvalids = 0;
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        for (int c = 0; c < 3; c++) clockCycle();
        checkOutput("stall_no_gnt", 32'(dut_grants), 32'h0);
        checkOutput("stall_no_rvalid", 32'(dut_rvalids), 32'h0);
        stall_i = 1'b0;
        clockCycle();
        checkOutput("gnt_after_stall", 32'(last_gnt), 32'h1);
        drain();

        // Reset with two responses queued; the granted write must survive.
        resp_hold_i = 1'b1;
        dut_grants = 0;
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h3C, 32'hCAFEF00D);
        clockCycle();
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        clockCycle();
        checkOutput("queued_two", 32'(dut_grants), 32'h2);
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_rvalid_now", 32'(rvalid_o), 32'h0);
        checkOutput("rst_gnt_now", 32'(gnt_o), 32'h0);
        q.delete();
        resp_hold_i = 1'b0;
        clockCycle();
        clockCycle();
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst_ni = 1'b1;
        dut_rvalids = 0;
        clockCycle();
        clockCycle();
        checkOutput("no_stale_rvalid", 32'(dut_rvalids), 32'h0);
        readBack("rd_after_reset", 32'h3C, 32'hCAFEF00D);

        // Randomized traffic checked cycle by cycle.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(2))
                    0:       a = BaseAddr + 32'(4 * MemWords) + 32'($urandom_range(255));
                    1:       a = 32'hFFFF_FFFC;
                    default: a = 32'h8000_0000 | 32'($urandom_range(1023));
                endcase
            end else begin
                a = BaseAddr + 32'(4 * $urandom_range(15)) + 32'($urandom_range(3));
            end
            applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)),
                          a, $urandom);
            stall_i     = ($urandom_range(3) == 0);
            resp_hold_i = ($urandom_range(3) == 0);
            clockCycle();
        end
        stall_i = 1'b0;
        resp_hold_i = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
